// File: rtl/line_write_merge.sv
// line_write_merge: merges 16-bit LC-3b stores into a 128-bit line with a per-byte dirty mask and writes it back.
// Define LINE_WMERGE_COALESCE_EN to coalesce same-line stores; otherwise every store is written back on its own.
module line_write_merge (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         st_valid,
  input  logic [15:0]  st_addr,
  input  logic [15:0]  st_wdata,
  input  logic [1:0]   st_byte_en,
  output logic         st_ready,
  input  logic         flush,
  output logic         flush_done,
  output logic         wb_req,
  output logic [15:0]  wb_addr,
  output logic [127:0] wb_data,
  output logic [15:0]  wb_mask,
  input  logic         wb_resp
);
  typedef enum logic [1:0] {EMPTY, FILL, WB} state_t;
  state_t       r_state, w_state_nxt;
  logic [11:0]  r_tag;
  logic [127:0] r_data, w_data_mrg;
  logic [15:0]  r_mask, w_mask_mrg;
  logic         r_flush_wb, w_flush_wb_nxt;
  logic         r_flush_done, r_flush_ack, w_flush_done_nxt;
  logic         w_accept, w_unused;
  logic [3:0]   w_b0, w_b1;

  assign w_b0     = {st_addr[3:1], 1'b0};
  assign w_b1     = {st_addr[3:1], 1'b1};
  assign w_unused = st_addr[0];
`ifdef LINE_WMERGE_COALESCE_EN
  logic w_hit;
  assign w_hit    = st_addr[15:4] == r_tag;
  assign st_ready = (|st_byte_en) & ~flush &
                    ((r_state == EMPTY) | ((r_state == FILL) & w_hit & (r_mask != 16'hFFFF)));
`else
  assign st_ready = (|st_byte_en) & ~flush & (r_state == EMPTY);
`endif
  assign w_accept   = st_valid & st_ready;
  assign wb_req     = r_state == WB;
  assign wb_addr    = {r_tag, 4'h0};
  assign wb_data    = r_data;
  assign wb_mask    = r_mask;
  assign flush_done = r_flush_done;

  // A new line starts from an empty mask; old data bytes stay but are not dirty
  always_comb begin
    w_mask_mrg = (r_state == EMPTY) ? 16'h0 : r_mask;
    w_data_mrg = r_data;
    if (st_byte_en[0]) begin
      w_mask_mrg[w_b0] = 1'b1;
      w_data_mrg[{w_b0, 3'b000} +: 8] = st_wdata[7:0];
    end
    if (st_byte_en[1]) begin
      w_mask_mrg[w_b1] = 1'b1;
      w_data_mrg[{w_b1, 3'b000} +: 8] = st_wdata[15:8];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_flush_wb_nxt = r_flush_wb;
    case (r_state)
      EMPTY: w_state_nxt = w_accept ? FILL : EMPTY;
      FILL: begin
`ifdef LINE_WMERGE_COALESCE_EN
        if (flush | (st_valid & (|st_byte_en) & ~w_hit) | (r_mask == 16'hFFFF)) begin
          w_state_nxt    = WB;
          w_flush_wb_nxt = flush;
        end
`else
        w_state_nxt    = WB;
        w_flush_wb_nxt = flush;
`endif
      end
      WB:      w_state_nxt = wb_resp ? EMPTY : WB;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // r_flush_ack keeps a held flush from pulsing flush_done more than once
  assign w_flush_done_nxt = flush & (((r_state == WB) & wb_resp & r_flush_wb) |
                                     ((r_state == EMPTY) & ~r_flush_ack));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY;
      r_tag        <= 12'h0;
      r_data       <= 128'h0;
      r_mask       <= 16'h0;
      r_flush_wb   <= 1'b0;
      r_flush_done <= 1'b0;
      r_flush_ack  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_wb   <= w_flush_wb_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_flush_ack  <= flush & (r_flush_ack | w_flush_done_nxt);
      if (w_accept) begin
        r_tag  <= st_addr[15:4];
        r_data <= w_data_mrg;
        r_mask <= w_mask_mrg;
      end else if ((r_state == WB) & wb_resp) begin
        r_mask <= 16'h0;
      end
    end
  end
endmodule
